fb_rxcounters: RTL and testbench

Receive-side counter and byte-assembly block for the FREEDM bus. It runs alongside the receive state machine and counts qualified nibbles per frame, per slave data field, per CRC field and per preamble. It generates the state-end strobes that the state machine uses to advance. It also packs received data nibbles into bytes and writes them into the receive RAM, with address generation and overflow protection.

---
 rtl/fb_rxcounters_if.sv | 31 +++
 rtl/fb_rxcounters.sv | 174 +++++++++++++++++
 tb/tb_fb_rxcounters.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_rxcounters_if.sv
// fb_rxcounters_if
//   Receive nibble stream and receive-RAM write bus of the FREEDM bus
//   receiver.
//   MRxDV, MRxD              : qualified receive nibble (PHY side)
//   RxRamAddr, RxRamData,
//   RxRamWe                  : byte write port into the receive RAM
//   master : the counter/byte-assembly block (consumes nibbles, drives RAM)
//   slave  : the PHY/RAM side
interface fb_rxcounters_if;
  logic       MRxDV;
  logic [3:0] MRxD;
  logic [7:0] RxRamAddr;
  logic [7:0] RxRamData;
  logic       RxRamWe;

  modport master (
    input  MRxDV,
    input  MRxD,
    output RxRamAddr,
    output RxRamData,
    output RxRamWe
  );

  modport slave (
    output MRxDV,
    output MRxD,
    input  RxRamAddr,
    input  RxRamData,
    input  RxRamWe
  );
endinterface

// File: rtl/fb_rxcounters.sv
// fb_rxcounters
//   Receive-side nibble counters and byte assembly for the FREEDM bus.
//   Counts qualified nibbles per frame, per slave data field, per CRC field
//   and per preamble, produces the state-end strobes for the receive FSM,
//   and packs data nibbles into bytes written to the receive RAM.
//   MTxClk, Reset        : clock, asynchronous active-high reset
//   rxBus                : nibble input and RAM write port (interface)
//   State*               : one-hot receive FSM state inputs
//   NibCnt, TotalNibCnt,
//   CrcNibCnt            : nibble counters
//   *StateEnd            : state-end strobes to the FSM
//   RxOverflow           : sticky, a byte was dropped because RAM was full
module fb_rxcounters #(
  parameter int DATA_NIBBLES     = 16,
  parameter int PREAMBLE_NIBBLES = 3
) (
  input  logic                   MTxClk,
  input  logic                   Reset,
  fb_rxcounters_if.master        rxBus,
  input  logic                   StateIdle,
  input  logic                   StatePreamble,
  input  logic                   StateSoC,
  input  logic                   StateCrc,
  input  logic                   StateFrmCrc,
  input  logic [1:0]             StateData,
  output logic [15:0]            NibCnt,
  output logic [15:0]            TotalNibCnt,
  output logic [3:0]             CrcNibCnt,
  output logic                   PreambleStateEnd,
  output logic                   DataStateEnd,
  output logic                   CrcStateEnd,
  output logic                   FrmCrcStateEnd,
  output logic                   RxOverflow
);

  localparam logic [15:0] DataLastNib    = 16'(DATA_NIBBLES - 1);
  localparam logic [3:0]  PreambleNeeded = 4'(PREAMBLE_NIBBLES);

  logic       v;
  logic       dataState;
  logic       nibClr;
  logic       addrClr;
  logic       anyActive;
  logic       highPair;
  logic       ramWrite;
  logic       ramDrop;
  logic [3:0] preambleNibCnt;
  logic [3:0] frmCrcNibCnt;
  logic [3:0] lowHold;
  logic       halfValid;
  logic       full;

  assign v         = rxBus.MRxDV;
  assign dataState = |StateData;
  assign nibClr    = StateIdle | StateSoC | StateCrc;
  assign addrClr   = StateIdle | StatePreamble | StateSoC;
  assign anyActive = ~StateIdle &
                     (StatePreamble | StateSoC | StateCrc | StateFrmCrc | dataState);

  // A high nibble completes a byte only if a low nibble is pending; the
  // clear term also covers StateIdle arriving together with a high nibble.
  assign highPair  = StateData[1] & v & halfValid & ~nibClr;
  assign ramWrite  = highPair & ~full;
  assign ramDrop   = highPair & full;

  assign DataStateEnd     = dataState & v & (NibCnt == DataLastNib);
  assign PreambleStateEnd = (preambleNibCnt >= PreambleNeeded);
  assign CrcStateEnd      = CrcNibCnt[0];
  assign FrmCrcStateEnd   = frmCrcNibCnt[0];

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset)
      NibCnt <= '0;
    else if (nibClr)
      NibCnt <= '0;
    else if (dataState && v && NibCnt != 16'hFFFF)
      NibCnt <= NibCnt + 16'd1;
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset)
      TotalNibCnt <= '0;
    else if (StateIdle)
      TotalNibCnt <= '0;
    else if (anyActive && v && TotalNibCnt != 16'hFFFF)
      TotalNibCnt <= TotalNibCnt + 16'd1;
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset)
      preambleNibCnt <= '0;
    else if (StateIdle)
      preambleNibCnt <= '0;
    else if (StatePreamble && v) begin
      if (rxBus.MRxD != 4'h5)
        preambleNibCnt <= '0;
      else if (preambleNibCnt != 4'hF)
        preambleNibCnt <= preambleNibCnt + 4'd1;
    end
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset)
      CrcNibCnt <= '0;
    else if (dataState)
      CrcNibCnt <= '0;
    else if (StateCrc && v)
      CrcNibCnt <= CrcNibCnt + 4'd1;
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset)
      frmCrcNibCnt <= '0;
    else if (StateCrc)
      frmCrcNibCnt <= '0;
    else if (StateFrmCrc && v)
      frmCrcNibCnt <= frmCrcNibCnt + 4'd1;
  end

  // Byte assembly: low nibble is held until its high nibble arrives.
  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      lowHold   <= '0;
      halfValid <= 1'b0;
    end else begin
      if (StateData[0] && v)
        lowHold <= rxBus.MRxD;
      if (nibClr)
        halfValid <= 1'b0;
      else if (StateData[0] && v)
        halfValid <= 1'b1;
      else if (highPair)
        halfValid <= 1'b0;
    end
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      rxBus.RxRamData <= '0;
      rxBus.RxRamWe   <= 1'b0;
    end else begin
      rxBus.RxRamWe <= ramWrite;
      if (ramWrite)
        rxBus.RxRamData <= {rxBus.MRxD, lowHold};
    end
  end

  // The address advances after the write cycle so that it holds the
  // target address while RxRamWe is high; it sticks at 8'hFF once full.
  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      rxBus.RxRamAddr <= '0;
      full            <= 1'b0;
    end else if (addrClr) begin
      rxBus.RxRamAddr <= '0;
      full            <= 1'b0;
    end else if (rxBus.RxRamWe) begin
      if (rxBus.RxRamAddr == 8'hFF)
        full <= 1'b1;
      else
        rxBus.RxRamAddr <= rxBus.RxRamAddr + 8'd1;
    end
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset)
      RxOverflow <= 1'b0;
    else if (StateIdle)
      RxOverflow <= 1'b0;
    else if (ramDrop)
      RxOverflow <= 1'b1;
  end

endmodule

// File: tb/tb_fb_rxcounters.sv
// tb_fb_rxcounters
//   Self-checking bench for fb_rxcounters (DATA_NIBBLES=16,
//   PREAMBLE_NIBBLES=3): a vector table covering preamble and one data
//   field, then hand-written sequences for CRC, v=0 gaps, idle abort,
//   RAM overflow and mid-frame reset.
module tb_fb_rxcounters;

  // State vector layout: {Idle, Preamble, SoC, Crc, FrmCrc, Data[1], Data[0]}
  localparam logic [6:0] S_IDLE = 7'b1000000;
  localparam logic [6:0] S_PRE  = 7'b0100000;
  localparam logic [6:0] S_SOC  = 7'b0010000;
  localparam logic [6:0] S_CRC  = 7'b0001000;
  localparam logic [6:0] S_FCRC = 7'b0000100;
  localparam logic [6:0] S_D1   = 7'b0000010;
  localparam logic [6:0] S_D0   = 7'b0000001;
  localparam logic [6:0] S_NONE = 7'b0000000;

  typedef struct {
    logic        dv;
    logic [3:0]  d;
    logic [6:0]  st;
    logic [15:0] eNib;
    logic        ePre;
    logic        eDse;
    logic        eWe;
    logic [7:0]  eAddr;
    logic [7:0]  eData;
  } vec_t;

  logic        MTxClk = 1'b0;
  logic        Reset;
  logic        StateIdle, StatePreamble, StateSoC, StateCrc, StateFrmCrc;
  logic [1:0]  StateData;
  logic [15:0] NibCnt, TotalNibCnt;
  logic [3:0]  CrcNibCnt;
  logic        PreambleStateEnd, DataStateEnd, CrcStateEnd, FrmCrcStateEnd;
  logic        RxOverflow;

  fb_rxcounters_if rxIf();

  fb_rxcounters #(.DATA_NIBBLES(16), .PREAMBLE_NIBBLES(3)) dut (
    .MTxClk           (MTxClk),
    .Reset            (Reset),
    .rxBus            (rxIf),
    .StateIdle        (StateIdle),
    .StatePreamble    (StatePreamble),
    .StateSoC         (StateSoC),
    .StateCrc         (StateCrc),
    .StateFrmCrc      (StateFrmCrc),
    .StateData        (StateData),
    .NibCnt           (NibCnt),
    .TotalNibCnt      (TotalNibCnt),
    .CrcNibCnt        (CrcNibCnt),
    .PreambleStateEnd (PreambleStateEnd),
    .DataStateEnd     (DataStateEnd),
    .CrcStateEnd      (CrcStateEnd),
    .FrmCrcStateEnd   (FrmCrcStateEnd),
    .RxOverflow       (RxOverflow)
  );

  always #5 MTxClk = ~MTxClk;

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a vector just after the falling edge; checks follow 1 ns later,
  // i.e. before the rising edge that samples these inputs.
  task automatic apply(input logic dv, input logic [3:0] d, input logic [6:0] st);
    @(negedge MTxClk);
    rxIf.MRxDV = dv;
    rxIf.MRxD  = d;
    {StateIdle, StatePreamble, StateSoC, StateCrc, StateFrmCrc, StateData} = st;
    #1;
  endtask

  function automatic vec_t mkv(input logic dv, input logic [3:0] d, input logic [6:0] st,
                               input logic [15:0] n, input logic p, input logic e,
                               input logic we, input logic [7:0] a, input logic [7:0] dat);
    vec_t r;
    r.dv = dv; r.d = d; r.st = st; r.eNib = n; r.ePre = p; r.eDse = e;
    r.eWe = we; r.eAddr = a; r.eData = dat;
    return r;
  endfunction

  // Byte k of the 1..F,0 data field: {nibble 2k+1, nibble 2k}.
  function automatic logic [7:0] byteOf(input int k);
    return {4'(2 * k + 2), 4'(2 * k + 1)};
  endfunction

  vec_t tbl [25];
  int   weCnt;

  initial begin
    Reset = 1'b1;
    rxIf.MRxDV = 1'b0;
    rxIf.MRxD  = 4'h0;
    {StateIdle, StatePreamble, StateSoC, StateCrc, StateFrmCrc, StateData} = S_NONE;

    // ---- table: idle, preamble 5,5,A,5,5,5, SoC, 16 data nibbles, CRC
    tbl[0] = mkv(1, 4'h0, S_IDLE, 16'd0, 0, 0, 0, 8'h00, 8'h00);
    tbl[1] = mkv(1, 4'h5, S_PRE,  16'd0, 0, 0, 0, 8'h00, 8'h00);
    tbl[2] = mkv(1, 4'h5, S_PRE,  16'd0, 0, 0, 0, 8'h00, 8'h00);
    tbl[3] = mkv(1, 4'hA, S_PRE,  16'd0, 0, 0, 0, 8'h00, 8'h00);
    tbl[4] = mkv(1, 4'h5, S_PRE,  16'd0, 0, 0, 0, 8'h00, 8'h00);
    tbl[5] = mkv(1, 4'h5, S_PRE,  16'd0, 0, 0, 0, 8'h00, 8'h00);
    tbl[6] = mkv(1, 4'h5, S_PRE,  16'd0, 0, 0, 0, 8'h00, 8'h00);
    tbl[7] = mkv(1, 4'hD, S_SOC,  16'd0, 1, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      logic        we;
      logic [7:0]  a, dat;
      if (i == 0) begin
        we = 0; a = 8'h00; dat = 8'h00;
      end else if (i % 2 == 0) begin
        we = 1; a = 8'(i / 2 - 1); dat = byteOf(i / 2 - 1);
      end else begin
        we = 0; a = 8'((i - 1) / 2);
        dat = (i >= 3) ? byteOf((i - 1) / 2 - 1) : 8'h00;
      end
      tbl[8 + i] = mkv(1, 4'(i + 1), (i % 2 == 1) ? S_D1 : S_D0,
                       16'(i), 1, (i == 15), we, a, dat);
    end
    tbl[24] = mkv(1, 4'h0, S_CRC, 16'd16, 1, 0, 1, 8'h07, 8'h0F);

    // ---- reset state
    repeat (2) @(negedge MTxClk);
    #1;
    chk("rst_NibCnt",      NibCnt, 0);
    chk("rst_TotalNibCnt", TotalNibCnt, 0);
    chk("rst_CrcNibCnt",   CrcNibCnt, 0);
    chk("rst_PreEnd",      PreambleStateEnd, 0);
    chk("rst_DataEnd",     DataStateEnd, 0);
    chk("rst_CrcEnd",      CrcStateEnd, 0);
    chk("rst_FrmCrcEnd",   FrmCrcStateEnd, 0);
    chk("rst_Addr",        rxIf.RxRamAddr, 0);
    chk("rst_Data",        rxIf.RxRamData, 0);
    chk("rst_We",          rxIf.RxRamWe, 0);
    chk("rst_Ovf",         RxOverflow, 0);
    @(negedge MTxClk);
    Reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].dv, tbl[i].d, tbl[i].st);
      chk($sformatf("tbl%0d_NibCnt", i),  NibCnt,           tbl[i].eNib);
      chk($sformatf("tbl%0d_PreEnd", i),  PreambleStateEnd, tbl[i].ePre);
      chk($sformatf("tbl%0d_DataEnd", i), DataStateEnd,     tbl[i].eDse);
      chk($sformatf("tbl%0d_We", i),      rxIf.RxRamWe,     tbl[i].eWe);
      chk($sformatf("tbl%0d_Addr", i),    rxIf.RxRamAddr,   tbl[i].eAddr);
      chk($sformatf("tbl%0d_Data", i),    rxIf.RxRamData,   tbl[i].eData);
    end

    // ---- CRC and frame CRC strobes, v=0 freeze
    apply(1, 4'h0, S_IDLE);
    apply(1, 4'h1, S_D0);
    apply(1, 4'h0, S_CRC);
    chk("crc_cnt0", CrcNibCnt, 0);
    chk("crc_end0", CrcStateEnd, 0);
    apply(0, 4'h0, S_CRC);
    chk("crc_cnt1", CrcNibCnt, 1);
    chk("crc_end1", CrcStateEnd, 1);
    apply(1, 4'h0, S_CRC);
    chk("crc_cnt1_gap", CrcNibCnt, 1);
    apply(1, 4'h0, S_FCRC);
    chk("crc_cnt2", CrcNibCnt, 2);
    chk("crc_end2", CrcStateEnd, 0);
    chk("fcrc_end0", FrmCrcStateEnd, 0);
    apply(1, 4'h0, S_FCRC);
    chk("fcrc_end1", FrmCrcStateEnd, 1);
    apply(1, 4'h0, S_IDLE);
    chk("fcrc_end2", FrmCrcStateEnd, 0);
    chk("crc_cnt_hold", CrcNibCnt, 2);

    // ---- v=0 gaps between low and high nibble, then idle aborts a pair
    apply(1, 4'h0, S_IDLE);
    apply(1, 4'h5, S_PRE);
    apply(1, 4'h0, S_SOC);
    apply(1, 4'h3, S_D0);
    apply(0, 4'h9, S_D1);
    chk("gap_nib1", NibCnt, 1);
    chk("gap_we1", rxIf.RxRamWe, 0);
    apply(0, 4'h9, S_D1);
    chk("gap_nib2", NibCnt, 1);
    apply(1, 4'hC, S_D1);
    chk("gap_nib3", NibCnt, 1);
    chk("gap_we3", rxIf.RxRamWe, 0);
    apply(0, 4'h0, S_D0);
    chk("gap_we", rxIf.RxRamWe, 1);
    chk("gap_data", rxIf.RxRamData, 8'hC3);
    chk("gap_addr", rxIf.RxRamAddr, 0);
    chk("gap_nib4", NibCnt, 2);
    chk("gap_total", TotalNibCnt, 4);
    apply(1, 4'h4, S_D0);
    chk("gap_we_off", rxIf.RxRamWe, 0);
    chk("gap_addr1", rxIf.RxRamAddr, 1);
    apply(1, 4'h9, S_IDLE | S_D1);
    apply(0, 4'h0, S_D0);
    chk("abort_we", rxIf.RxRamWe, 0);
    chk("abort_nib", NibCnt, 0);
    chk("abort_total", TotalNibCnt, 0);
    chk("abort_addr", rxIf.RxRamAddr, 0);

    // ---- overflow: 257 back-to-back bytes
    apply(1, 4'h0, S_IDLE);
    apply(1, 4'h0, S_SOC);
    weCnt = 0;
    for (int k = 0; k < 257; k++) begin
      apply(1, 4'(k), S_D0);
      if (rxIf.RxRamWe) begin
        weCnt++;
        chk($sformatf("ovf_addr%0d", weCnt - 1), rxIf.RxRamAddr, 32'(weCnt - 1));
      end
      apply(1, 4'(k + 3), S_D1);
      if (rxIf.RxRamWe) begin
        weCnt++;
        chk("ovf_we_on_high", 0, 1);
      end
      if (k == 256) begin
        chk("ovf_addr_stuck", rxIf.RxRamAddr, 8'hFF);
        chk("ovf_flag_before", RxOverflow, 0);
      end
    end
    apply(0, 4'h0, S_D0);
    chk("ovf_last_we", rxIf.RxRamWe, 0);
    chk("ovf_flag", RxOverflow, 1);
    chk("ovf_we_count", weCnt, 256);
    chk("ovf_addr_final", rxIf.RxRamAddr, 8'hFF);
    apply(1, 4'h0, S_CRC);
    chk("ovf_hold_crc", RxOverflow, 1);
    apply(1, 4'h0, S_SOC);
    chk("ovf_hold_crc2", RxOverflow, 1);
    apply(1, 4'h0, S_IDLE);
    chk("ovf_hold_soc", RxOverflow, 1);
    apply(0, 4'h0, S_IDLE);
    chk("ovf_clr_idle", RxOverflow, 0);

    // ---- asynchronous reset between low and high nibble
    apply(1, 4'h0, S_IDLE);
    apply(1, 4'h0, S_SOC);
    apply(1, 4'h7, S_D0);
    apply(0, 4'h0, S_D1);
    chk("mid_nib_pre", NibCnt, 1);
    chk("mid_total_pre", TotalNibCnt, 2);
    Reset = 1'b1;
    #1;
    chk("mid_nib", NibCnt, 0);
    chk("mid_total", TotalNibCnt, 0);
    chk("mid_addr", rxIf.RxRamAddr, 0);
    chk("mid_data", rxIf.RxRamData, 0);
    chk("mid_we", rxIf.RxRamWe, 0);
    @(negedge MTxClk);
    Reset = 1'b0;
    apply(1, 4'h8, S_D1);
    apply(0, 4'h0, S_D1);
    chk("mid_no_write", rxIf.RxRamWe, 0);
    chk("mid_addr_after", rxIf.RxRamAddr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
